// File: rtl/semaphore_ctrl.sv
// semaphore_ctrl: round-robin sequencer driving a bank of semaphore units.
// Ports: clk, reset (async, active-high), tick, req, unit_done | unit_en,
//   unit_next, active_dir, busy, seq_err. Option: SEM_CTRL_ALL_RED_EN.
module semaphore_ctrl #(
  parameter int N_DIR   = 4,
  parameter int CNT_W   = 16,
  parameter int RY_CYC  = 2,
  parameter int GRN_CYC = 10,
  parameter int YEL_CYC = 3,
  parameter int AR_CYC  = 2,
  localparam int DIR_W  = $clog2(N_DIR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [N_DIR-1:0] req,
  input  logic [N_DIR-1:0] unit_done,
  output logic [N_DIR-1:0] unit_en,
  output logic             unit_next,
  output logic [DIR_W-1:0] active_dir,
  output logic             busy,
  output logic             seq_err
);

  if (N_DIR < 2 || CNT_W < 1 || RY_CYC < 1 || GRN_CYC < 1 ||
      YEL_CYC < 1 || AR_CYC < 1) begin : g_bad_cfg
    $error("semaphore_ctrl: invalid parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RY,
    S_GRN,
    S_YEL,
    S_CHK
`ifdef SEM_CTRL_ALL_RED_EN
    , S_AR
`endif
  } state_t;

  state_t state_q, state_d;

  logic [N_DIR-1:0] unit_en_q, unit_en_d;
  logic             unit_next_q, unit_next_d;
  logic [DIR_W-1:0] active_dir_q, active_dir_d;
  logic             busy_q, busy_d;
  logic             seq_err_q, seq_err_d;
  logic [N_DIR-1:0] pending_q, pending_d;
  logic [DIR_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic [N_DIR-1:0] pend_eff;
  logic [N_DIR-1:0] clr;
  logic [DIR_W-1:0] pick;
  logic             any_pend;
  logic             expire;
  int               j;

  // A request arriving in the IDLE cycle is served without an extra
  // cycle of latching.
  assign pend_eff = pending_q | req;
  assign any_pend = |pend_eff;
  assign expire   = tick && (timer_q == CNT_W'(1));

  // Scan from the far end so the nearest set bit after rr_q wins.
  always_comb begin
    pick = rr_q;
    j    = 0;
    for (int k = N_DIR; k >= 1; k--) begin
      j = (int'(rr_q) + k) % N_DIR;
      if (pend_eff[j]) pick = DIR_W'(j);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      unit_en_q    <= '0;
      unit_next_q  <= 1'b0;
      active_dir_q <= '0;
      busy_q       <= 1'b0;
      seq_err_q    <= 1'b0;
      pending_q    <= '0;
      rr_q         <= DIR_W'(N_DIR - 1);
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      unit_en_q    <= unit_en_d;
      unit_next_q  <= unit_next_d;
      active_dir_q <= active_dir_d;
      busy_q       <= busy_d;
      seq_err_q    <= seq_err_d;
      pending_q    <= pending_d;
      rr_q         <= rr_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_pend) state_d = S_RY;
      S_RY:   if (expire) state_d = S_GRN;
      S_GRN:  if (expire) state_d = S_YEL;
      S_YEL:  if (expire) state_d = S_CHK;
`ifdef SEM_CTRL_ALL_RED_EN
      S_CHK:  state_d = S_AR;
      S_AR:   if (expire) state_d = S_IDLE;
`else
      S_CHK:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unit_en_d    = unit_en_q;
    unit_next_d  = 1'b0;
    active_dir_d = active_dir_q;
    rr_d         = rr_q;
    timer_d      = timer_q;
    seq_err_d    = seq_err_q;
    clr          = '0;
    unique case (state_q)
      S_IDLE: begin
        if (any_pend) begin
          unit_en_d    = N_DIR'(1) << pick;
          active_dir_d = pick;
          rr_d         = pick;
          unit_next_d  = 1'b1;
          timer_d      = CNT_W'(RY_CYC);
        end
      end
      S_RY: begin
        if (tick) timer_d = timer_q - CNT_W'(1);
        if (expire) begin
          unit_next_d = 1'b1;
          timer_d     = CNT_W'(GRN_CYC);
          clr         = unit_en_q;
        end
      end
      S_GRN: begin
        if (tick) timer_d = timer_q - CNT_W'(1);
        if (expire) begin
          unit_next_d = 1'b1;
          timer_d     = CNT_W'(YEL_CYC);
        end
      end
      S_YEL: begin
        if (tick) timer_d = timer_q - CNT_W'(1);
        if (expire) unit_next_d = 1'b1;
      end
      S_CHK: begin
        unit_en_d = '0;
        // Unit sits in yellow now, so the served unit must report done.
        if (~|(unit_done & unit_en_q)) seq_err_d = 1'b1;
`ifdef SEM_CTRL_ALL_RED_EN
        timer_d = CNT_W'(AR_CYC);
`endif
      end
`ifdef SEM_CTRL_ALL_RED_EN
      S_AR: begin
        if (tick) timer_d = timer_q - CNT_W'(1);
      end
`endif
      default: ;
    endcase
    // Set beats clear: a req in the green-entry cycle re-queues.
    pending_d = (pending_q & ~clr) | req;
    busy_d    = (state_d != S_IDLE);
  end

  assign unit_en    = unit_en_q;
  assign unit_next  = unit_next_q;
  assign active_dir = active_dir_q;
  assign busy       = busy_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_semaphore_ctrl.sv
// tb_semaphore_ctrl: random + directed stimulus, transaction-level model,
// scoreboard of expected unit_next pulses checked by a separate monitor.
module tb_semaphore_ctrl;
  localparam int N   = 4;
  localparam int RY  = 2;
  localparam int GRN = 10;
  localparam int YEL = 3;
  localparam int AR  = 2;
  localparam int DW  = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [N-1:0]  req;
  logic [N-1:0]  unit_done;
  logic [N-1:0]  unit_en;
  logic          unit_next;
  logic [DW-1:0] active_dir;
  logic          busy;
  logic          seq_err;

  int checks = 0;
  int errors = 0;

  semaphore_ctrl #(
    .N_DIR(N), .CNT_W(16), .RY_CYC(RY), .GRN_CYC(GRN),
    .YEL_CYC(YEL), .AR_CYC(AR)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
    .unit_done(unit_done), .unit_en(unit_en), .unit_next(unit_next),
    .active_dir(active_dir), .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    int dir;
  } exp_t;

  exp_t sbq[$];
  int   plog[$];
  int   dlog[$];
  int   edge_cnt = 0;

  // Reference model: a service is four pulses separated by phase
  // lengths counted in ticks, then one check cycle.
  int       m_dir  = -1;
  int       m_np   = 0;
  int       m_tk   = 0;
  int       m_ptr  = N - 1;
  int       m_last = 0;
  bit       m_err  = 1'b0;
  bit       m_ar   = 1'b0;
  bit [N-1:0] m_pend = '0;
  int       len [3] = '{RY, GRN, YEL};
  bit [N-1:0] eff;
  int       d;
  bit       found;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (reset) begin
      m_dir = -1; m_np = 0; m_tk = 0; m_ptr = N - 1;
      m_last = 0; m_err = 1'b0; m_ar = 1'b0; m_pend = '0;
      sbq.delete();
    end else begin
      eff = m_pend | req;
      if (m_ar) begin
        if (tick) begin
          m_tk++;
          if (m_tk == AR) m_ar = 1'b0;
        end
      end else if (m_dir < 0) begin
        if (eff != 0) begin
          found = 1'b0;
          d = 0;
          for (int k = 1; k <= N; k++)
            if (!found && eff[(m_ptr + k) % N]) begin
              found = 1'b1;
              d = (m_ptr + k) % N;
            end
          m_dir = d; m_ptr = d; m_last = d;
          m_np = 1; m_tk = 0;
          sbq.push_back('{stamp: edge_cnt, dir: d});
          dlog.push_back(d);
        end
      end else if (m_np < 4) begin
        if (tick) begin
          m_tk++;
          if (m_tk == len[m_np-1]) begin
            if (m_np == 1) m_pend[m_dir] = 1'b0;
            m_np++;
            m_tk = 0;
            sbq.push_back('{stamp: edge_cnt, dir: m_dir});
          end
        end
      end else begin
        if (!unit_done[m_dir]) m_err = 1'b1;
        m_dir = -1;
`ifdef SEM_CTRL_ALL_RED_EN
        m_ar = 1'b1;
        m_tk = 0;
`endif
      end
      m_pend = m_pend | req;
    end
  end

  exp_t e;
  logic [N-1:0] exp_en;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("rst_en", unit_en, 0);
      check("rst_next", unit_next, 0);
      check("rst_dir", active_dir, 0);
      check("rst_busy", busy, 0);
      check("rst_err", seq_err, 0);
    end else begin
      if (unit_next) plog.push_back(edge_cnt);
      if (sbq.size() > 0 && sbq[0].stamp == edge_cnt) begin
        e = sbq.pop_front();
        check("next_pulse", unit_next, 1);
        check("next_dir", active_dir, e.dir);
      end else begin
        check("next_quiet", unit_next, 0);
      end
      exp_en = (m_dir >= 0) ? (N'(1) << m_dir) : '0;
      check("unit_en", unit_en, exp_en);
      check("busy", busy, (m_dir >= 0) || m_ar);
      check("active_dir", active_dir, m_last);
      check("seq_err", seq_err, m_err);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    plog.delete();
    dlog.delete();
  endtask

  int t1_edge;

  initial begin
    reset = 1'b1;
    tick = 1'b1;
    req = '0;
    unit_done = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    plog.delete();
    dlog.delete();

    // Single pulse request on dir 2, tick always high.
    @(negedge clk);
    req = 4'b0100;
    t1_edge = edge_cnt + 1;
    @(negedge clk);
    req = '0;
    repeat (25) @(negedge clk);
    check("t1_npulses", plog.size(), 4);
    if (plog.size() >= 4) begin
      check("t1_first", plog[0], t1_edge);
      check("t1_ry", plog[1] - plog[0], RY);
      check("t1_grn", plog[2] - plog[1], GRN);
      check("t1_yel", plog[3] - plog[2], YEL);
    end
    check("t1_dir", active_dir, 2);
    check("t1_busy", busy, 0);
    check("t1_err", seq_err, 0);

    // All directions held: strict round robin from dir 0.
    do_reset();
    req = '1;
    repeat (120) @(negedge clk);
    check("t2_count", dlog.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      if (i < dlog.size()) check("t2_order", dlog[i], i % N);
    req = '0;

    // Slow timebase, then random timebase and demand.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tick = (c % 4 == 0);
      req = ($urandom_range(15) == 0) ? N'($urandom) : '0;
    end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      tick = ($urandom_range(2) == 0);
      req = ($urandom_range(9) == 0) ? N'($urandom) : '0;
    end
    check("t3_err", seq_err, 0);

    // Missing done: sticky error across later services.
    @(negedge clk);
    tick = 1'b1;
    unit_done = '0;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (90) @(negedge clk);
    check("t4_err_set", seq_err, 1);
    unit_done = '1;
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    repeat (60) @(negedge clk);
    check("t4_err_sticky", seq_err, 1);

    // Reset in the middle of dir 2 green with dir 0 also queued.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    check("t5_in_svc", unit_en, 4'b0100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dlog.delete();
    repeat (10) @(negedge clk);
    check("t5_idle", busy, 0);
    check("t5_nosvc", dlog.size(), 0);
    req = '1;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check("t5_first", dlog.size() > 0 ? dlog[0] : -1, 0);

    repeat (80) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
